// File: rtl/sram_mem_controller.sv
// ============================================================================
// sram_mem_controller
// ----------------------------------------------------------------------------
// Sequences MEM-stage loads and stores onto the external 256K x 16
// asynchronous SRAM. Each 32-bit access becomes two 16-bit SRAM cycles (low
// half first, then high half), followed by WAIT_CYCLES idle cycles and a
// DONE cycle. While an access is in flight `ready` is low; the top level
// freezes every pipeline register and the PC with freeze = ~ready.
//
// Parameters:
//   BASE_ADDR   - byte address of the data-memory origin (default 1024)
//   WAIT_CYCLES - idle cycles after the high half-access, 0..15 (default 2)
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   wr_en, rd_en    - store / load request levels, held while ready = 0
//   address         - word-aligned byte address from the ALU
//   write_data      - 32-bit store data
//   read_data       - 32-bit load result, held until the next load
//   ready           - 0 while an access is in progress
//   SRAM_DQ         - bidirectional 16-bit SRAM data bus
//   SRAM_ADDR       - 18-bit half-word address
//   SRAM_WE_N/OE_N  - active-low write / output enables
//   SRAM_CE_N/UB_N/LB_N - tied low (chip always selected, both bytes)
//
// Optional feature (macro SRAM_ACCESS_COUNT_EN):
//   Adds rd_count[15:0] / wr_count[15:0], counting completed loads and
//   stores on entry to DONE. Both wrap at 0xFFFF and reset to 0.
// ============================================================================
module sram_mem_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
`ifdef SRAM_ACCESS_COUNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WAIT,
        DONE
    } state_t;

    // Value loaded into the wait counter on HIGH -> WAIT; unused when there
    // are no wait cycles, so it is clamped to keep the subtraction in range.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        opWrite_q, opWrite_d;
    logic [16:0] word_q, word_d;
    logic [31:0] data_q, data_d;
    logic [31:0] readData_q, readData_d;
    logic [3:0]  waitCnt_q, waitCnt_d;

    logic [31:0] offset;
    logic        unusedOffsetBits;
    logic        driveDq;
    logic [15:0] dqOut;

    // Only bits [18:2] of the offset form the SRAM word index; anything
    // above is dropped, so out-of-range addresses wrap silently.
    assign offset           = address - BASE_ADDR;
    assign unusedOffsetBits = ^{offset[31:19], offset[1:0]};

    // Next-state and SRAM control decode. Bus controls depend only on the
    // registered state, so an asynchronous reset releases the bus at once.
    always_comb begin
        state_d    = state_q;
        opWrite_d  = opWrite_q;
        word_d     = word_q;
        data_d     = data_q;
        readData_d = readData_q;
        waitCnt_d  = waitCnt_q;
        SRAM_ADDR  = {word_q, 1'b0};
        SRAM_WE_N  = 1'b1;
        SRAM_OE_N  = 1'b0;
        driveDq    = 1'b0;
        dqOut      = data_q[15:0];

        case (state_q)
            IDLE: begin
                if (wr_en || rd_en) begin
                    state_d   = LOW;
                    opWrite_d = wr_en;
                    word_d    = offset[18:2];
                    data_d    = write_data;
                end
            end
            LOW: begin
                SRAM_ADDR = {word_q, 1'b0};
                if (opWrite_q) begin
                    SRAM_WE_N = 1'b0;
                    SRAM_OE_N = 1'b1;
                    driveDq   = 1'b1;
                    dqOut     = data_q[15:0];
                end else begin
                    readData_d[15:0] = SRAM_DQ;
                end
                state_d = HIGH;
            end
            HIGH: begin
                SRAM_ADDR = {word_q, 1'b1};
                if (opWrite_q) begin
                    SRAM_WE_N = 1'b0;
                    SRAM_OE_N = 1'b1;
                    driveDq   = 1'b1;
                    dqOut     = data_q[31:16];
                end else begin
                    readData_d[31:16] = SRAM_DQ;
                end
                if (WAIT_CYCLES > 0) begin
                    state_d   = WAIT;
                    waitCnt_d = WAIT_LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            opWrite_q  <= 1'b0;
            word_q     <= '0;
            data_q     <= '0;
            readData_q <= '0;
            waitCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            opWrite_q  <= opWrite_d;
            word_q     <= word_d;
            data_q     <= data_d;
            readData_q <= readData_d;
            waitCnt_q  <= waitCnt_d;
        end
    end

`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0] rdCount_q, rdCount_d;
    logic [15:0] wrCount_q, wrCount_d;

    // Count each access once, on the transition into DONE.
    always_comb begin
        rdCount_d = rdCount_q;
        wrCount_d = wrCount_q;
        if (state_d == DONE && state_q != DONE) begin
            if (opWrite_q) begin
                wrCount_d = wrCount_q + 16'd1;
            end else begin
                rdCount_d = rdCount_q + 16'd1;
            end
        end
    end

    // Access counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdCount_q <= '0;
            wrCount_q <= '0;
        end else begin
            rdCount_q <= rdCount_d;
            wrCount_q <= wrCount_d;
        end
    end

    assign rd_count = rdCount_q;
    assign wr_count = wrCount_q;
`endif

    // ready stays high whenever the MEM stage has no request, and rises in
    // DONE so the pipeline advances exactly once per completed access.
    assign ready     = ~(wr_en | rd_en) | (state_q == DONE);
    assign read_data = readData_q;
    assign SRAM_DQ   = driveDq ? dqOut : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
